// File: rtl/reg_dump_reader.sv
// Register read-back streamer: after a start request and a settle delay, captures
// reg1..reg8 plus OV in one cycle and streams them as eight indexed words.
module reg_dump_reader #(
  parameter int DW     = 32,
  parameter int SETTLE = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [DW-1:0] reg1,
  input  logic [DW-1:0] reg2,
  input  logic [DW-1:0] reg3,
  input  logic [DW-1:0] reg4,
  input  logic [DW-1:0] reg5,
  input  logic [DW-1:0] reg6,
  input  logic [DW-1:0] reg7,
  input  logic [DW-1:0] reg8,
  input  logic          OV,
  output logic [DW-1:0] out_data,
  output logic [2:0]    out_idx,
  output logic          out_ovf,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          busy,
  output logic          done
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_SEND,
    ST_DONE
  } state_t;

  state_t        state_reg, state_next;
  logic [7:0]    cnt_reg, cnt_next;
  logic [2:0]    idx_reg, idx_next;
  logic          capture;
  logic          ovf_reg;
  logic [DW-1:0] snapshot_reg [8];
  logic [DW-1:0] reg_in [8];

  assign reg_in[0] = reg1;
  assign reg_in[1] = reg2;
  assign reg_in[2] = reg3;
  assign reg_in[3] = reg4;
  assign reg_in[4] = reg5;
  assign reg_in[5] = reg6;
  assign reg_in[6] = reg7;
  assign reg_in[7] = reg8;

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    idx_next   = idx_reg;
    capture    = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          state_next = ST_SETTLE;
          cnt_next   = 8'(SETTLE);
        end
      end
      ST_SETTLE: begin
        if (cnt_reg == 8'd0) begin
          capture    = 1'b1;
          state_next = ST_SEND;
          idx_next   = 3'd0;
        end else begin
          cnt_next = cnt_reg - 8'd1;
        end
      end
      ST_SEND: begin
        // idx never wraps: the beat at index 7 ends the stream
        if (out_ready) begin
          if (idx_reg == 3'd7) state_next = ST_DONE;
          else                 idx_next   = idx_reg + 3'd1;
        end
      end
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= 8'd0;
      idx_reg   <= 3'd0;
      ovf_reg   <= 1'b0;
      for (int i = 0; i < 8; i++) snapshot_reg[i] <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      idx_reg   <= idx_next;
      if (capture) begin
        ovf_reg <= OV;
        for (int i = 0; i < 8; i++) snapshot_reg[i] <= reg_in[i];
      end
    end
  end

  // All outputs decode registered state only; nothing from reg1..reg8 reaches them directly.
  assign out_valid = (state_reg == ST_SEND);
  assign out_data  = out_valid ? snapshot_reg[idx_reg] : '0;
  assign out_idx   = out_valid ? idx_reg : 3'd0;
  assign out_ovf   = out_valid ? ovf_reg : 1'b0;
  assign busy      = (state_reg == ST_SETTLE) || (state_reg == ST_SEND);
  assign done      = (state_reg == ST_DONE);

endmodule

// File: tb/tb_reg_dump_reader.sv
// Directed bench for reg_dump_reader: expected beats are queued when start is
// driven and popped as the DUT transfers each word.
module tb_reg_dump_reader;

  typedef struct {
    logic [2:0]  idx;
    logic [31:0] data;
    logic        ovf;
  } beat_t;

  logic        clk = 1'b0;
  logic        reset, start, ov, out_ready;
  logic [31:0] r [8];
  logic [31:0] out_data;
  logic [2:0]  out_idx;
  logic        out_ovf, out_valid, busy, done;

  int    checks = 0;
  int    errors = 0;
  int    cyc = 0;
  int    c0;
  beat_t sb [$];

  always #5 clk = ~clk;

  reg_dump_reader #(.DW(32), .SETTLE(2)) dut (
    .clk(clk), .reset(reset), .start(start),
    .reg1(r[0]), .reg2(r[1]), .reg3(r[2]), .reg4(r[3]),
    .reg5(r[4]), .reg6(r[5]), .reg7(r[6]), .reg8(r[7]),
    .OV(ov), .out_data(out_data), .out_idx(out_idx), .out_ovf(out_ovf),
    .out_valid(out_valid), .out_ready(out_ready), .busy(busy), .done(done)
  );

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic send_start(output int c_start);
    beat_t b;
    start = 1'b1;
    for (int i = 0; i < 8; i++) begin
      b.idx  = 3'(i);
      b.data = r[i];
      b.ovf  = ov;
      sb.push_back(b);
    end
    c_start = cyc;
    tick();
    start = 1'b0;
  endtask

  // Monitor one dump. rdy_mod>1 raises out_ready every rdy_mod-th cycle.
  // abort_beat>0 returns in the cycle after that many transfers.
  task automatic drain(input int rdy_mod, input bit start_mid, input int abort_beat,
                       input bit mutate, input int cs);
    int          beats = 0;
    int          dones = 0;
    bit          held = 0;
    bit          fin = 0;
    logic [31:0] hd;
    logic [2:0]  hi;
    logic        ho;
    beat_t       e;
    for (int t = 0; t < 200 && !fin; t++) begin
      out_ready = (rdy_mod <= 1) ? 1'b1 : ((t % rdy_mod) == rdy_mod - 1);
      start = start_mid && out_valid && (out_idx == 3'd3);
      if (mutate && cyc == cs + 4) begin
        r[2] = 32'd999;
        ov   = 1'b1;
      end
      if (out_valid) begin
        chk("busy_in_send", busy, 1);
        if (held) begin
          chk("hold_data", out_data, hd);
          chk("hold_idx", out_idx, hi);
          chk("hold_ovf", out_ovf, ho);
        end
        hd = out_data; hi = out_idx; ho = out_ovf; held = 1;
        if (out_ready) begin
          held = 0;
          chk("sb_nonempty", sb.size() > 0, 1);
          if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("beat_idx", out_idx, e.idx);
            chk("beat_data", out_data, e.data);
            chk("beat_ovf", out_ovf, e.ovf);
          end
          if (rdy_mod <= 1) chk("beat_cycle", cyc, cs + 4 + beats);
          $display("beat idx=%0d data=%08h ovf=%0b cycle=%0d", out_idx, out_data, out_ovf, cyc);
          beats++;
        end
      end else begin
        chk("novalid_idx", out_idx, 0);
        chk("novalid_data", out_data, 0);
      end
      if (done) begin
        dones++;
        chk("done_ovf", out_ovf, 0);
        chk("done_after_8", beats, 8);
        if (rdy_mod <= 1) chk("done_cycle", cyc, cs + 12);
        fin = 1;
      end
      tick();
      if (abort_beat > 0 && beats == abort_beat) fin = 1;
    end
    start = 1'b0;
    chk("drain_finished", fin, 1);
    if (abort_beat == 0) begin
      chk("done_count", dones, 1);
      chk("sb_drained", sb.size(), 0);
      chk("done_one_cycle", done, 0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; start = 1'b1; ov = 1'b0; out_ready = 1'b1;
    r[0] = 32'd345; r[1] = 32'd456; r[2] = 32'd801; r[3] = 32'd200;
    r[4] = 32'd511; r[5] = 32'hFFFF_FC00; r[6] = 32'd0; r[7] = 32'd0;

    // 1: reset held with start high
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_valid", out_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_data", out_data, 0);
      chk("rst_idx", out_idx, 0);
    end
    reset = 1'b0; start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("post_rst_busy", busy, 0);
    end

    // 2: straight dump, ready always high
    send_start(c0);
    drain(1, 0, 0, 0, c0);

    // 3: ready only every third cycle
    send_start(c0);
    drain(3, 0, 0, 0, c0);

    // 4: inputs change after capture
    send_start(c0);
    drain(1, 0, 0, 1, c0);
    r[2] = 32'd801; ov = 1'b0;

    // 5a: start pulsed mid-stream is ignored
    send_start(c0);
    drain(1, 1, 0, 0, c0);
    for (int i = 0; i < 5; i++) begin
      chk("no_queued_start", busy, 0);
      tick();
    end

    // 5b: random data with OV=1, then start right after done
    for (int i = 0; i < 8; i++) r[i] = $urandom;
    ov = 1'b1;
    send_start(c0);
    drain(1, 0, 0, 0, c0);
    ov = 1'b0;
    r[7] = 32'hDEAD_BEEF;
    send_start(c0);
    drain(1, 0, 0, 0, c0);

    // 6: reset after beat 4 aborts the dump
    send_start(c0);
    drain(1, 0, 4, 0, c0);
    reset = 1'b1; out_ready = 1'b0;
    tick();
    reset = 1'b0; out_ready = 1'b1;
    chk("abort_valid", out_valid, 0);
    chk("abort_idx", out_idx, 0);
    chk("abort_busy", busy, 0);
    sb.delete();
    for (int i = 0; i < 12; i++) begin
      chk("abort_no_done", done, 0);
      chk("abort_idle", busy, 0);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
